vga_scan_gen: RTL and testbench

- Raster timing generator for the 2048 VGA display: 640x480@60 Hz.
- Divides the board clock down to a pixel-rate tick.
- Runs the horizontal and vertical scan counters, drives hsync/vsync, and produces the count_h/count_v/flag/num_h/num_v set consumed directly by the VGA pixel-colour stage.
- Also emits a one-cycle frame_start pulse that game logic uses to latch board updates between frames.

---
 rtl/vga_scan_gen.sv | 94 +++++++++
 tb/tb_vga_scan_gen.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - 640x480@60 raster timing generator with pixel-rate divider and board cell decode
module vga_scan_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 515
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic [9:0] count_h,
  output logic [9:0] count_v,
  output logic       hsync,
  output logic       vsync,
  output logic       flag,
  output logic [1:0] num_h,
  output logic [1:0] num_v,
  output logic       frame_start
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_LO = 10'(H_ACT_START);
  localparam logic [9:0] H_ACT_HI = 10'(H_ACT_END);
  localparam logic [9:0] V_ACT_LO = 10'(V_ACT_START);
  localparam logic [9:0] V_ACT_HI = 10'(V_ACT_END);

  logic [3:0] div_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;

  // Cells are (b0,b1], (b1,b2], (b2,b3], (b3,b4]; cell 0 and out-of-board both decode to 0,
  // so the lower edge b0 never needs its own comparator.
  function automatic logic [1:0] cell_idx(input logic [9:0] c, input logic [9:0] b1,
                                          input logic [9:0] b2, input logic [9:0] b3,
                                          input logic [9:0] b4);
    logic [1:0] idx;
    idx = 2'd0;
    if (c > b1 && c <= b2)      idx = 2'd1;
    else if (c > b2 && c <= b3) idx = 2'd2;
    else if (c > b3 && c <= b4) idx = 2'd3;
    return idx;
  endfunction

  // pix_tick doubles as the advance enable, so counters move one clk after it rises.
  always_comb begin
    h_nxt = count_h;
    v_nxt = count_v;
    if (pix_tick) begin
      if (count_h == H_LAST) begin
        h_nxt = 10'd0;
        v_nxt = (count_v == V_LAST) ? 10'd0 : count_v + 10'd1;
      end else begin
        h_nxt = count_h + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= 4'd0;
      pix_tick    <= 1'b0;
      count_h     <= 10'd0;
      count_v     <= 10'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      flag        <= 1'b0;
      num_h       <= 2'd0;
      num_v       <= 2'd0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
      pix_tick    <= (div_cnt == DIV_LAST);
      count_h     <= h_nxt;
      count_v     <= v_nxt;
      hsync       <= (h_nxt >= H_SYNC_W);
      vsync       <= (v_nxt >= V_SYNC_W);
      flag        <= (h_nxt >= H_ACT_LO) && (h_nxt < H_ACT_HI) &&
                     (v_nxt >= V_ACT_LO) && (v_nxt < V_ACT_HI);
      num_h       <= cell_idx(h_nxt, 10'd362, 10'd462, 10'd562, 10'd670);
      num_v       <= cell_idx(v_nxt, 10'd172, 10'd272, 10'd372, 10'd480);
      frame_start <= pix_tick && (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - directed bench for vga_scan_gen using three short-frame parameterisations
module tb_vga_scan_gen;

  logic clk;
  logic rst_a;
  logic rst_b;

  logic       a_pix, a_hs, a_vs, a_flag, a_fs;
  logic [9:0] a_h, a_v;
  logic [1:0] a_nh, a_nv;
  logic       b_pix, b_hs, b_vs, b_flag, b_fs;
  logic [9:0] b_h, b_v;
  logic [1:0] b_nh, b_nv;
  logic       c_pix, c_hs, c_vs, c_flag, c_fs;
  logic [9:0] c_h, c_v;
  logic [1:0] c_nh, c_nv;

  int n_cmp;
  int n_bad;

  // a: default horizontal timing, 3-line frame
  vga_scan_gen #(.CLK_DIV(4), .H_TOTAL(800), .H_SYNC(96), .H_ACT_START(144), .H_ACT_END(784),
                 .V_TOTAL(3), .V_SYNC(2), .V_ACT_START(1), .V_ACT_END(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .pix_tick(a_pix), .count_h(a_h), .count_v(a_v), .hsync(a_hs),
    .vsync(a_vs), .flag(a_flag), .num_h(a_nh), .num_v(a_nv), .frame_start(a_fs));

  // b: default vertical timing, 16-tick lines, one clk per pixel
  vga_scan_gen #(.CLK_DIV(1), .H_TOTAL(16), .H_SYNC(2), .H_ACT_START(4), .H_ACT_END(12),
                 .V_TOTAL(525), .V_SYNC(2), .V_ACT_START(35), .V_ACT_END(515)) dut_b (
    .clk(clk), .rst_n(rst_b), .pix_tick(b_pix), .count_h(b_h), .count_v(b_v), .hsync(b_hs),
    .vsync(b_vs), .flag(b_flag), .num_h(b_nh), .num_v(b_nv), .frame_start(b_fs));

  // c: CLK_DIV = 1 with the default 800-tick line
  vga_scan_gen #(.CLK_DIV(1), .H_TOTAL(800), .H_SYNC(96), .H_ACT_START(144), .H_ACT_END(784),
                 .V_TOTAL(3), .V_SYNC(2), .V_ACT_START(1), .V_ACT_END(2)) dut_c (
    .clk(clk), .rst_n(rst_a), .pix_tick(c_pix), .count_h(c_h), .count_v(c_v), .hsync(c_hs),
    .vsync(c_vs), .flag(c_flag), .num_h(c_nh), .num_v(c_nv), .frame_start(c_fs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_a_h(input int h, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (a_h == 10'(h)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_b(input int h, input int v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (b_v == 10'(v) && (h < 0 || b_h == 10'(h))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({a_pix, a_fs, a_hs, a_vs, a_flag, a_nh, a_nv, a_h, a_v} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_a: got %h want 0", {a_pix, a_fs, a_hs, a_vs, a_flag, a_nh, a_nv, a_h, a_v});
    end
    n_cmp++;
    if ({b_pix, b_fs, b_hs, b_vs, b_flag, b_nh, b_nv, b_h, b_v} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_b: got %h want 0", {b_pix, b_fs, b_hs, b_vs, b_flag, b_nh, b_nv, b_h, b_v});
    end
    n_cmp++;
    if ({c_pix, c_fs, c_hs, c_vs, c_flag, c_nh, c_nv, c_h, c_v} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_c: got %h want 0", {c_pix, c_fs, c_hs, c_vs, c_flag, c_nh, c_nv, c_h, c_v});
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({a_pix, a_h} !== {1'b0, 10'd0}) begin
        n_bad++;
        $display("FAIL release_a_edge%0d: pix=%b h=%0d want pix=0 h=0", k + 1, a_pix, a_h);
      end
      n_cmp++;
      if ({c_pix, c_h} !== {1'b1, 10'(k)}) begin
        n_bad++;
        $display("FAIL release_c_edge%0d: pix=%b h=%0d want pix=1 h=%0d", k + 1, c_pix, c_h, k);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({a_pix, a_h, a_fs} !== {1'b1, 10'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL first_tick_a: pix=%b h=%0d fs=%b want pix=1 h=0 fs=0", a_pix, a_h, a_fs);
    end
    @(negedge clk);
    n_cmp++;
    if ({a_pix, a_h} !== {1'b0, 10'd1}) begin
      n_bad++;
      $display("FAIL first_advance_a: pix=%b h=%0d want pix=0 h=1", a_pix, a_h);
    end
  endtask

  task automatic test_line_timing;
    bit ok;
    int n;
    logic [9:0] h0, v0;
    wait_a_h(799, ok);
    h0 = a_h;
    v0 = a_v;
    n = 0;
    while (a_h == 10'd799 && n < 8) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!ok || {h0, v0, a_h, a_v} !== {10'd799, 10'd0, 10'd0, 10'd1}) begin
      n_bad++;
      $display("FAIL line_wrap: got (%0d,%0d)->(%0d,%0d) want (799,0)->(0,1)", h0, v0, a_h, a_v);
    end
    n = 0;
    while (a_hs === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n != 384 || a_h !== 10'd96) begin
      n_bad++;
      $display("FAIL hsync_width: low %0d clks ending at h=%0d want 384 ending at h=96", n, a_h);
    end
  endtask

  task automatic test_active_window;
    bit ok;
    int hs [4];
    bit fe [4];
    hs = '{143, 144, 783, 784};
    fe = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      wait_a_h(hs[i], ok);
      n_cmp++;
      if (!ok || a_v !== 10'd1 || a_flag !== fe[i]) begin
        n_bad++;
        $display("FAIL flag_h%0d: v=%0d flag=%b want v=1 flag=%b", hs[i], a_v, a_flag, fe[i]);
      end
    end
  endtask

  task automatic test_cell_h;
    bit ok;
    int hs [8];
    logic [1:0] ne [8];
    hs = '{263, 362, 363, 462, 463, 600, 670, 671};
    ne = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 8; i++) begin
      wait_a_h(hs[i], ok);
      n_cmp++;
      if (!ok || a_v !== 10'd2 || {a_nh, a_nv, a_flag} !== {ne[i], 2'd0, 1'b0}) begin
        n_bad++;
        $display("FAIL cell_h%0d: v=%0d num_h=%0d num_v=%0d flag=%b want v=2 num_h=%0d num_v=0 flag=0",
                 hs[i], a_v, a_nh, a_nv, a_flag, ne[i]);
      end
    end
  endtask

  task automatic test_frame_wrap;
    bit ok;
    int nfs;
    int vlow;
    ok = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (a_fs === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok || {a_h, a_v} !== 20'd0) begin
      n_bad++;
      $display("FAIL frame_start_1: found=%b h=%0d v=%0d want found=1 h=0 v=0", ok, a_h, a_v);
    end
    nfs = 0;
    vlow = 0;
    for (int i = 0; i < 9600; i++) begin
      if (i > 0 && a_fs === 1'b1) nfs++;
      if (a_vs === 1'b0) vlow++;
      @(negedge clk);
    end
    n_cmp++;
    if (vlow != 6400) begin
      n_bad++;
      $display("FAIL vsync_width_1: low %0d clks want 6400", vlow);
    end
    n_cmp++;
    if (nfs != 0 || a_fs !== 1'b1 || {a_h, a_v} !== 20'd0) begin
      n_bad++;
      $display("FAIL frame_period: extra=%0d fs_at_9600=%b h=%0d v=%0d want extra=0 fs=1 h=0 v=0",
               nfs, a_fs, a_h, a_v);
    end
    nfs = 0;
    vlow = 0;
    for (int i = 0; i < 6500; i++) begin
      if (i > 0 && a_fs === 1'b1) nfs++;
      if (a_vs === 1'b0) vlow++;
      @(negedge clk);
    end
    n_cmp++;
    if (vlow != 6400 || nfs != 0) begin
      n_bad++;
      $display("FAIL vsync_width_2: low %0d clks extra_fs=%0d want 6400 and 0", vlow, nfs);
    end
  endtask

  task automatic test_clk_div1;
    int n;
    n = 0;
    while (c_h != 10'd799 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({c_pix, c_h} !== {1'b1, 10'(k)}) begin
        n_bad++;
        $display("FAIL div1_step%0d: pix=%b h=%0d want pix=1 h=%0d", k, c_pix, c_h, k);
      end
    end
    n = 4;
    while (c_h != 10'd0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n != 800) begin
      n_bad++;
      $display("FAIL div1_line: %0d clks want 800", n);
    end
  endtask

  task automatic test_cell_v;
    bit ok;
    int vs [12];
    logic [1:0] ne [12];
    vs = '{60, 61, 73, 172, 173, 272, 273, 300, 373, 400, 480, 481};
    ne = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    for (int i = 0; i < 12; i++) begin
      wait_b(-1, vs[i], ok);
      n_cmp++;
      if (!ok || {b_nh, b_nv} !== {2'd0, ne[i]}) begin
        n_bad++;
        $display("FAIL cell_v%0d: found=%b num_h=%0d num_v=%0d want num_h=0 num_v=%0d",
                 vs[i], ok, b_nh, b_nv, ne[i]);
      end
    end
  endtask

  task automatic test_active_v;
    bit ok;
    int hs [8];
    int vs [8];
    bit fe [8];
    hs = '{4, 3, 4, 11, 12, 4, 11, 4};
    vs = '{34, 35, 35, 35, 35, 514, 514, 515};
    fe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      wait_b(hs[i], vs[i], ok);
      n_cmp++;
      if (!ok || b_flag !== fe[i]) begin
        n_bad++;
        $display("FAIL flag_v(%0d,%0d): found=%b flag=%b want %b", hs[i], vs[i], ok, b_flag, fe[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    wait_b(-1, 200, ok);
    rst_b = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!ok || {b_pix, b_fs, b_hs, b_vs, b_flag, b_nh, b_nv, b_h, b_v} !== 29'd0) begin
      n_bad++;
      $display("FAIL mid_reset: found=%b got %h want 0", ok,
               {b_pix, b_fs, b_hs, b_vs, b_flag, b_nh, b_nv, b_h, b_v});
    end
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({b_pix, b_h, b_fs} !== {1'b1, 10'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_release_1: pix=%b h=%0d fs=%b want pix=1 h=0 fs=0", b_pix, b_h, b_fs);
    end
    @(negedge clk);
    n_cmp++;
    if ({b_h, b_v, b_fs} !== {10'd1, 10'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_release_2: h=%0d v=%0d fs=%b want h=1 v=0 fs=0", b_h, b_v, b_fs);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    test_reset;
    test_line_timing;
    test_active_window;
    test_cell_h;
    test_frame_wrap;
    test_clk_div1;
    test_cell_v;
    test_active_v;
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
